// File: rtl/fifo_cfg_pkg.sv
// Shared configuration for param_sync_fifo: default sizes, pointer-width helper
// and the packed status-flag record used by the top level.
package fifo_cfg_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;

  // Pointers and the occupancy count need one bit beyond the address width.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
    logic parity_err;
  } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset; only the read register returns to zero.
module fifo_dpram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int ENTRIES = 1 << AW;

  logic [DW-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register holds its value between accepted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky
// error flags. Optional storage parity is enabled by defining FIFO_PARITY_EN.
module param_sync_fifo
  import fifo_cfg_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err,
  output logic                      parity_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = ptr_w(DEPTH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of 2 and at least 4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH must be at least 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must lie in 1..DEPTH-1");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 2) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must lie in 0..DEPTH-2");
  end

`ifdef FIFO_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  logic [PW-1:0] wptr, rptr;
  logic [PW-1:0] count_next;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          par_bad;
  fifo_status_t  st, st_next;

  // Acceptance uses the registered flags, so a full FIFO refuses a write even
  // when a read is accepted in the same cycle.
  assign wr_acc = wr_en & ~st.full;
  assign rd_acc = rd_en & ~st.empty;

`ifdef FIFO_PARITY_EN
  assign mem_wdata = {^wr_data, wr_data};
  assign par_bad   = rd_valid & (^mem_rdata);
`else
  assign mem_wdata = wr_data;
  assign par_bad   = 1'b0;
`endif

  fifo_dpram #(
    .DW (DW),
    .AW (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .re    (rd_acc),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign rd_data = mem_rdata[WIDTH-1:0];

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + PW'(1);
    else if (rd_acc && !wr_acc) count_next = count - PW'(1);
  end

  // Flags are derived from the next count so they line up with the count register;
  // a new error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    st_next              = st;
    st_next.full         = (count_next == PW'(DEPTH));
    st_next.empty        = (count_next == '0);
    st_next.almost_full  = (count_next >= PW'(AF_THRESH));
    st_next.almost_empty = (count_next <= PW'(AE_THRESH));
    st_next.overflow     = (wr_en & st.full)  | (st.overflow  & ~clr_err);
    st_next.underflow    = (rd_en & st.empty) | (st.underflow & ~clr_err);
    st_next.parity_err   = par_bad            | (st.parity_err & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      st       <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                    overflow: 1'b0, underflow: 1'b0, parity_err: 1'b0};
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
      count    <= count_next;
      rd_valid <= rd_acc;
      st       <= st_next;
    end
  end

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
  // The mismatch is visible in the rd_valid cycle itself, then held by the register.
  assign parity_err   = st.parity_err | par_bad;

  // The wrap-bit pointer distance must always equal the occupancy count.
  ptr_count_consistent: assert property (@(posedge clk) disable iff (rst)
    (wptr - rptr) == count);

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed, table-driven bench for param_sync_fifo (DEPTH=16, AF=12, AE=4),
// with hand-written sequences for simultaneous access, wrap-around and reset.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty;
  logic        overflow, underflow, parity_err;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        rd;
    logic        clr;
    int          cnt;
    logic [5:0]  flg;
    logic        vld;
    logic [31:0] q;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model[$];

  param_sync_fifo #(
    .WIDTH     (32),
    .DEPTH     (16),
    .AF_THRESH (12),
    .AE_THRESH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Expected {full, empty, almost_full, almost_empty, overflow, underflow}.
  function automatic logic [5:0] mk(input int cnt, input logic o, input logic u);
    return {cnt == 16, cnt == 0, cnt >= 12, cnt <= 4, o, u};
  endfunction

  function automatic logic [5:0] cur_flags();
    return {full, empty, almost_full, almost_empty, overflow, underflow};
  endfunction

  task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r,
                               input logic c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input int cnt, input logic [5:0] flg);
    checkOutput({tag, " count"}, 32'(count), 32'(cnt));
    checkOutput({tag, " flags"}, 32'(cur_flags()), 32'(flg));
  endtask

  initial begin
    logic [31:0] exp_q;
    logic [3:0]  idx;

    // Initial reset
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 0, mk(0, 1'b0, 1'b0));
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;

    // Fill 0..15, overflow attempt, drain, underflow attempt, clear
    for (int i = 0; i < 16; i++)
      vecs.push_back('{wr: 1'b1, data: 32'(i), rd: 1'b0, clr: 1'b0, cnt: i + 1,
                       flg: mk(i + 1, 1'b0, 1'b0), vld: 1'b0, q: 32'd0});
    vecs.push_back('{wr: 1'b1, data: 32'hDEAD, rd: 1'b0, clr: 1'b0, cnt: 16,
                     flg: mk(16, 1'b1, 1'b0), vld: 1'b0, q: 32'd0});
    for (int j = 0; j < 16; j++)
      vecs.push_back('{wr: 1'b0, data: 32'd0, rd: 1'b1, clr: 1'b0, cnt: 15 - j,
                       flg: mk(15 - j, 1'b1, 1'b0), vld: 1'b1, q: 32'(j)});
    vecs.push_back('{wr: 1'b0, data: 32'd0, rd: 1'b1, clr: 1'b0, cnt: 0,
                     flg: mk(0, 1'b1, 1'b1), vld: 1'b0, q: 32'd0});
    vecs.push_back('{wr: 1'b0, data: 32'd0, rd: 1'b0, clr: 1'b1, cnt: 0,
                     flg: mk(0, 1'b0, 1'b0), vld: 1'b0, q: 32'd0});

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].wr, vecs[n].data, vecs[n].rd, vecs[n].clr);
      checkState($sformatf("vec%0d", n), vecs[n].cnt, vecs[n].flg);
      checkOutput($sformatf("vec%0d rd_valid", n), 32'(rd_valid), 32'(vecs[n].vld));
      if (vecs[n].vld) checkOutput($sformatf("vec%0d rd_data", n), rd_data, vecs[n].q);
      checkOutput($sformatf("vec%0d parity_err", n), 32'(parity_err), 32'd0);
    end

    // Simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(100 + i), 1'b0, 1'b0);
    checkState("pre5", 5, mk(5, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'(105 + k), 1'b1, 1'b0);
      checkOutput("both count", 32'(count), 32'd5);
      checkOutput("both rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("both rd_data", rd_data, 32'(100 + k));
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("both drain", rd_data, 32'(110 + k));
    end
    checkState("both end", 0, mk(0, 1'b0, 1'b0));

    // Simultaneous at full: read wins, write rejected
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(200 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBAD, 1'b1, 1'b0);
    checkState("full both", 15, mk(15, 1'b1, 1'b0));
    checkOutput("full both rd_data", rd_data, 32'd200);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("full drain", rd_data, 32'(201 + k));
    end
    checkState("full drained", 0, mk(0, 1'b1, 1'b0));
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);

    // Simultaneous at empty: write wins, read rejected
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    checkState("empty both", 1, mk(1, 1'b0, 1'b1));
    checkOutput("empty both rd_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("empty both rd_data", rd_data, 32'h55);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkState("empty cleared", 0, mk(0, 1'b0, 1'b0));

    // Wrap-around against a queue model, count kept at 9..10
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
      model.push_back(32'h1000 + 32'(i));
    end
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 32'h2000 + 32'(k), 1'b0, 1'b0);
      model.push_back(32'h2000 + 32'(k));
      checkState("wrap wr", 10, mk(10, 1'b0, 1'b0));
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      exp_q = model.pop_front();
      checkOutput("wrap rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("wrap rd_data", rd_data, exp_q);
      checkState("wrap rd", 9, mk(9, 1'b0, 1'b0));
    end
    while (model.size() > 0) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      exp_q = model.pop_front();
      checkOutput("wrap drain", rd_data, exp_q);
    end
    checkState("wrap end", 0, mk(0, 1'b0, 1'b0));
    checkOutput("wrap parity_err", 32'(parity_err), 32'd0);

`ifdef FIFO_PARITY_EN
    // Corrupt one stored bit and expect the error on its rd_valid cycle
    applyStimulus(1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0);
    idx = dut.rptr[3:0];
    dut.u_ram.mem[idx][5] = ~dut.u_ram.mem[idx][5];
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("parity rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("parity_err on read", 32'(parity_err), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("parity_err sticky", 32'(parity_err), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("parity_err cleared", 32'(parity_err), 32'd0);
`else
    idx = 4'd0;
    checkOutput("parity_err off", 32'(parity_err) | 32'(idx), 32'd0);
`endif

    // Asynchronous reset mid-cycle discards contents
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("pre-reset rd_valid", 32'(rd_valid), 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkState("async reset", 0, mk(0, 1'b0, 1'b0));
    checkOutput("async reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("async reset rd_data", rd_data, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h777, 1'b0, 1'b0);
    checkState("post-reset wr", 1, mk(1, 1'b0, 1'b0));
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("post-reset rd_data", rd_data, 32'h777);
    checkState("post-reset end", 0, mk(0, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
